// File: rtl/usb_mailbox_if.sv
`default_nettype none
// ============================================================================
// Module      : usb_mailbox_if
// Description : picorv32 native memory bus bundle between the CPU and the
//               USB command mailbox.
// Revision    : 1.0 - initial release
// ============================================================================
interface usb_mailbox_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    // CPU side issues requests and receives the acknowledge.
    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    // Mailbox side decodes requests and returns data.
    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/usb_mailbox.sv
`default_nettype none
// ============================================================================
// Module      : usb_mailbox
// Description : Host/CPU command mailbox. Snapshots the host input buffer on
//               a synchronised trigger, flags the command to the CPU, and
//               exposes a CPU-writable output buffer plus status to the host.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_mailbox #(
    parameter int          MEMORY_WIDTH = 8,
    parameter int          MEMORY_BYTES = 1 << MEMORY_WIDTH,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
    input  wire logic                      clk_sys,
    input  wire logic                      resetn,
    input  wire logic                      trigger,
    input  wire logic [MEMORY_BYTES*8-1:0] memory_input,
    output logic      [MEMORY_BYTES*8-1:0] memory_output,
    usb_mailbox_if.slave                   bus,
    output logic                           cmd_irq
);
    localparam int          c_bits  = MEMORY_BYTES * 8;
    localparam int          c_aw    = MEMORY_WIDTH - 2;
    localparam logic [31:0] c_bytes = 32'(MEMORY_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_PENDING = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_sync1, r_sync2, r_sync3, r_trig_rise;
    logic               r_overrun;
    logic               r_cmd_irq;
    logic               r_mem_ready;
    logic [31:0]        r_mem_rdata;
    logic [c_bits-1:0]  r_snapshot;
    logic [c_bits-1:0]  r_outbuf;

    logic [11:0]        w_off;
    logic [c_aw-1:0]    w_word;
    int                 w_base;
    logic               w_hit, w_wr, w_in_range;
    logic               w_sel_snap, w_sel_obuf, w_sel_stat, w_sel_ctrl;
    logic               w_ctrl_done, w_ctrl_clr;
    logic               w_pending, w_done;
    logic [7:0]         w_status;
    logic [31:0]        w_rdata;
    logic               w_unused_addr;

    // Address decode; the low two address bits are ignored (word accesses).
    assign w_off         = bus.mem_addr[11:0];
    assign w_unused_addr = &{1'b0, w_off[1:0]};
    assign w_word        = w_off[MEMORY_WIDTH-1:2];
    assign w_base        = 32 * int'(w_word);
    assign w_hit         = bus.mem_valid & (bus.mem_addr[31:12] == BASE_ADDR[31:12]) & ~r_mem_ready;
    assign w_wr          = w_hit & (|bus.mem_wstrb);
    assign w_in_range    = ({22'd0, w_off[9:0]} < c_bytes);
    assign w_sel_snap    = (w_off[11:10] == 2'b00) & w_in_range;
    assign w_sel_obuf    = (w_off[11:10] == 2'b01) & w_in_range;
    assign w_sel_stat    = (w_off[11:2] == 10'h200);
    assign w_sel_ctrl    = (w_off[11:2] == 10'h201);
    assign w_ctrl_done   = w_wr & w_sel_ctrl & bus.mem_wstrb[0] & bus.mem_wdata[0];
    assign w_ctrl_clr    = w_wr & w_sel_ctrl & bus.mem_wstrb[0] & bus.mem_wdata[1];

    assign w_pending     = (r_state == ST_CAPTURE) | (r_state == ST_PENDING);
    assign w_done        = (r_state == ST_DONE);
    assign w_status      = {5'b0, r_overrun, w_pending, w_done};

    // Trigger crosses into clk_sys through two flops, then a registered rising-edge detect.
    always_ff @(posedge clk_sys) begin
        if (!resetn) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync3     <= 1'b0;
            r_trig_rise <= 1'b0;
        end else begin
            r_sync1     <= trigger;
            r_sync2     <= r_sync1;
            r_sync3     <= r_sync2;
            r_trig_rise <= r_sync2 & ~r_sync3;
        end
    end

    // Command state register.
    always_ff @(posedge clk_sys) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Command sequencing: capture on trigger, wait for CPU done.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (r_trig_rise) w_state_nxt = ST_CAPTURE;
            ST_CAPTURE:       w_state_nxt = ST_PENDING;
            ST_PENDING:       if (w_ctrl_done) w_state_nxt = ST_DONE;
            default:          w_state_nxt = ST_IDLE;
        endcase
    end

    // IRQ registered from the next state so it tracks PENDING without extra lag.
    always_ff @(posedge clk_sys) begin
        if (!resetn) r_cmd_irq <= 1'b0;
        else         r_cmd_irq <= (w_state_nxt == ST_PENDING);
    end

    // Overrun: a trigger arriving while a command is in flight; setting beats clearing.
    always_ff @(posedge clk_sys) begin
        if (!resetn)                         r_overrun <= 1'b0;
        else if (r_trig_rise & w_pending)    r_overrun <= 1'b1;
        else if (w_ctrl_clr)                 r_overrun <= 1'b0;
    end

    // Coherent full-width copy of the host buffer during the capture cycle.
    always_ff @(posedge clk_sys) begin
        if (!resetn)                     r_snapshot <= '0;
        else if (r_state == ST_CAPTURE)  r_snapshot <= memory_input;
    end

    // CPU byte-lane writes into the output buffer.
    always_ff @(posedge clk_sys) begin
        if (!resetn) begin
            r_outbuf <= '0;
        end else if (w_wr & w_sel_obuf) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_wstrb[b]) r_outbuf[w_base + 8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
        end
    end

    // Read data mux; unmapped offsets and the control register read as zero.
    always_comb begin
        w_rdata = '0;
        if (w_sel_snap)      w_rdata = r_snapshot[w_base +: 32];
        else if (w_sel_obuf) w_rdata = r_outbuf[w_base +: 32];
        else if (w_sel_stat) w_rdata = {24'd0, w_status};
    end

    // One-cycle acknowledge; rdata is held at zero outside the ready cycle.
    always_ff @(posedge clk_sys) begin
        if (!resetn) begin
            r_mem_ready <= 1'b0;
            r_mem_rdata <= '0;
        end else begin
            r_mem_ready <= w_hit;
            r_mem_rdata <= (w_hit & ~(|bus.mem_wstrb)) ? w_rdata : 32'd0;
        end
    end

    assign bus.mem_ready = r_mem_ready;
    assign bus.mem_rdata = r_mem_rdata;
    assign cmd_irq       = r_cmd_irq;
    // Top host-visible byte carries status instead of the stored buffer byte.
    assign memory_output = {w_status, r_outbuf[c_bits-9:0]};

endmodule
`default_nettype wire

// File: tb/tb_usb_mailbox.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_mailbox
// Description : Directed self-checking bench for usb_mailbox with a
//               byte-array mailbox model and a per-cycle output compare.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_mailbox;
    localparam int          MB   = 256;
    localparam int          BITS = MB * 8;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic            clk_sys = 1'b0;
    logic            resetn  = 1'b0;
    logic            trigger = 1'b0;
    logic [BITS-1:0] mem_in  = '0;
    logic [BITS-1:0] mem_out;
    logic            cmd_irq;
    logic [31:0]     rd;

    usb_mailbox_if bus();

    usb_mailbox #(
        .MEMORY_WIDTH (8),
        .MEMORY_BYTES (MB),
        .BASE_ADDR    (BASE)
    ) dut (
        .clk_sys       (clk_sys),
        .resetn        (resetn),
        .trigger       (trigger),
        .memory_input  (mem_in),
        .memory_output (mem_out),
        .bus           (bus),
        .cmd_irq       (cmd_irq)
    );

    always #5 clk_sys = ~clk_sys;

    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;
    logic prev_ready = 1'b0;

    // Mailbox model: snapshot and output buffers as byte arrays plus flags.
    logic [7:0] m_snap [MB];
    logic [7:0] m_out  [MB];
    bit         m_pend, m_done, m_ovr;

    function automatic void model_reset();
        for (int i = 0; i < MB; i++) begin
            m_snap[i] = 8'h00;
            m_out[i]  = 8'h00;
        end
        m_pend = 1'b0;
        m_done = 1'b0;
        m_ovr  = 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] off);
        int b;
        b = int'({off[11:2], 2'b00});
        if (b < MB) return {m_snap[b+3], m_snap[b+2], m_snap[b+1], m_snap[b]};
        if (b >= 'h400 && b < 'h400 + MB)
            return {m_out[b-'h400+3], m_out[b-'h400+2], m_out[b-'h400+1], m_out[b-'h400]};
        if (b == 'h800) return {29'd0, m_ovr, m_pend, m_done};
        return 32'd0;
    endfunction

    function automatic void model_write(input logic [11:0] off, input logic [31:0] wd, input logic [3:0] ws);
        int b;
        b = int'({off[11:2], 2'b00});
        if (b >= 'h400 && b < 'h400 + MB) begin
            for (int k = 0; k < 4; k++)
                if (ws[k]) m_out[b - 'h400 + k] = wd[8*k +: 8];
        end
        if (b == 'h804 && ws[0]) begin
            if (wd[0] && m_pend) begin
                m_pend = 1'b0;
                m_done = 1'b1;
            end
            if (wd[1]) m_ovr = 1'b0;
        end
    endfunction

    function automatic logic [7:0] model_out_byte(input int k);
        if (k == MB - 1) return {5'b0, m_ovr, m_pend, m_done};
        return m_out[k];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Per-cycle compare of bus protocol and host/IRQ outputs against the model.
    always @(negedge clk_sys) begin
        int bad;
        if (resetn) begin
            tests++;
            if (prev_ready && bus.mem_ready) begin
                fails++;
                $display("FAIL ready_b2b: got back-to-back ready want single pulse");
            end
            if (!bus.mem_ready) begin
                tests++;
                if (bus.mem_rdata !== 32'd0) begin
                    fails++;
                    $display("FAIL rdata_idle: got %h want 00000000", bus.mem_rdata);
                end
            end
        end
        prev_ready = bus.mem_ready;
        if (chk_en) begin
            bad = -1;
            for (int k = 0; k < MB; k++)
                if (bad < 0 && mem_out[8*k +: 8] !== model_out_byte(k)) bad = k;
            tests++;
            if (bad >= 0) begin
                fails++;
                $display("FAIL outbus byte %0d: got %h want %h", bad, mem_out[8*bad +: 8], model_out_byte(bad));
            end
            tests++;
            if (cmd_irq !== m_pend) begin
                fails++;
                $display("FAIL cmd_irq: got %b want %b", cmd_irq, m_pend);
            end
        end
    end

    // One CPU access; checks the 1-cycle acknowledge and keeps the model in step.
    task automatic cpu(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                       output logic [31:0] rdat);
        int n;
        bit got;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = wd;
        bus.mem_wstrb = ws;
        n   = 0;
        got = 1'b0;
        while (!got && n < 5) begin
            @(posedge clk_sys);
            #1;
            n++;
            if (bus.mem_ready) got = 1'b1;
        end
        rdat = bus.mem_rdata;
        tests++;
        if (!got || n != 1) begin
            fails++;
            $display("FAIL ready_latency addr %h: got %0d cycles (seen=%0d) want 1", addr, n, got);
        end
        if (got) begin
            if (ws == 4'd0) chk("model_rd", rdat, model_read(addr[11:0]));
            else            model_write(addr[11:0], wd, ws);
        end
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'd0;
        @(posedge clk_sys);
        #1;
    endtask

    // Host trigger expected to start a capture.
    task automatic trig_capture();
        int n;
        bit got;
        chk_en  = 1'b0;
        trigger = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(posedge clk_sys);
            #1;
            n++;
            if (cmd_irq) got = 1'b1;
        end
        tests++;
        if (!got || n < 4 || n > 5) begin
            fails++;
            $display("FAIL irq_latency: got %0d cycles (seen=%0d) want 4..5", n, got);
        end
        for (int k = 0; k < MB; k++) m_snap[k] = mem_in[8*k +: 8];
        m_pend  = 1'b1;
        m_done  = 1'b0;
        trigger = 1'b0;
        chk_en  = 1'b1;
        repeat (4) @(posedge clk_sys);
        #1;
    endtask

    // Host trigger arriving while a command is already pending.
    task automatic trig_ignored();
        chk_en  = 1'b0;
        trigger = 1'b1;
        repeat (6) @(posedge clk_sys);
        #1;
        m_ovr   = 1'b1;
        chk_en  = 1'b1;
        trigger = 1'b0;
        repeat (4) @(posedge clk_sys);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.mem_valid = 1'b0;
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;
        bus.mem_wstrb = 4'd0;
        model_reset();
        repeat (3) @(posedge clk_sys);
        #1;
        resetn = 1'b1;
        chk_en = 1'b1;

        // Reset state
        chk("rst_irq", 32'(cmd_irq), 32'd0);
        chk("rst_outbus", 32'(|mem_out), 32'd0);
        cpu(BASE + 32'h800, 32'd0, 4'd0, rd); chk("status_rst", rd, 32'd0);
        cpu(BASE + 32'h804, 32'd0, 4'd0, rd); chk("ctrl_read", rd, 32'd0);

        // First command capture
        mem_in[31:0]        = 32'h4433_2211;
        mem_in[BITS-1 -: 32] = 32'hF0E0_D0C0;
        trig_capture();
        cpu(BASE + 32'h000, 32'd0, 4'd0, rd); chk("snap_w0", rd, 32'h4433_2211);
        cpu(BASE + 32'h800, 32'd0, 4'd0, rd); chk("status_pend", rd, 32'h2);
        chk("top_pend", 32'(mem_out[BITS-1 -: 8]), 32'h02);
        cpu(BASE + 32'h0FC, 32'd0, 4'd0, rd); chk("snap_top", rd, 32'hF0E0_D0C0);

        // Snapshot coherence and read-only behaviour
        mem_in[31:0] = 32'h9988_7766;
        repeat (2) @(posedge clk_sys);
        #1;
        cpu(BASE + 32'h000, 32'd0, 4'd0, rd); chk("snap_coherent", rd, 32'h4433_2211);
        cpu(BASE + 32'h000, 32'hFFFF_FFFF, 4'hF, rd);
        cpu(BASE + 32'h000, 32'd0, 4'd0, rd); chk("snap_ro", rd, 32'h4433_2211);

        // Output buffer writes with byte strobes
        cpu(BASE + 32'h400, 32'hAABB_CCDD, 4'b0101, rd);
        chk("outbus_w0", mem_out[31:0], 32'h00BB_00DD);
        cpu(BASE + 32'h400, 32'd0, 4'd0, rd); chk("obuf_rd", rd, 32'h00BB_00DD);
        cpu(BASE + 32'h4FC, 32'h5A00_0000, 4'b1000, rd);
        chk("top_masked", 32'(mem_out[BITS-1 -: 8]), 32'h02);
        cpu(BASE + 32'h4FC, 32'd0, 4'd0, rd); chk("obuf_top_rd", rd, 32'h5A00_0000);

        // Unmapped offset in the window
        cpu(BASE + 32'hC00, 32'h1234_5678, 4'hF, rd);
        cpu(BASE + 32'hC00, 32'd0, 4'd0, rd); chk("unmapped_rd", rd, 32'd0);

        // Command completion
        cpu(BASE + 32'h804, 32'h1, 4'hF, rd);
        chk("irq_done", 32'(cmd_irq), 32'd0);
        cpu(BASE + 32'h800, 32'd0, 4'd0, rd); chk("status_done", rd, 32'h1);
        chk("top_done", 32'(mem_out[BITS-1 -: 8]), 32'h01);

        // New command from DONE, then an overrun while pending
        mem_in[31:0] = 32'h0D0C_0B0A;
        trig_capture();
        cpu(BASE + 32'h800, 32'd0, 4'd0, rd); chk("status_pend2", rd, 32'h2);
        mem_in[31:0] = 32'hDEAD_BEEF;
        trig_ignored();
        cpu(BASE + 32'h800, 32'd0, 4'd0, rd); chk("status_ovr", rd, 32'h6);
        cpu(BASE + 32'h000, 32'd0, 4'd0, rd); chk("snap_no_recap", rd, 32'h0D0C_0B0A);
        cpu(BASE + 32'h804, 32'h2, 4'hF, rd);
        cpu(BASE + 32'h800, 32'd0, 4'd0, rd); chk("status_clr", rd, 32'h2);

        // Outside the window: never acknowledged
        bus.mem_valid = 1'b1;
        bus.mem_addr  = BASE + 32'h1000;
        bus.mem_wstrb = 4'd0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_sys);
            #1;
            chk("no_ready_oow", 32'(bus.mem_ready), 32'd0);
        end
        bus.mem_valid = 1'b0;
        @(posedge clk_sys);
        #1;

        // Reset while a command is pending and an access is in flight
        chk_en        = 1'b0;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = BASE + 32'h800;
        resetn        = 1'b0;
        @(posedge clk_sys);
        #1;
        chk("rst_mid_ready", 32'(bus.mem_ready), 32'd0);
        chk("rst_mid_irq", 32'(cmd_irq), 32'd0);
        chk("rst_mid_outbus", 32'(|mem_out), 32'd0);
        bus.mem_valid = 1'b0;
        @(posedge clk_sys);
        #1;
        resetn = 1'b1;
        model_reset();
        chk_en = 1'b1;
        cpu(BASE + 32'h800, 32'd0, 4'd0, rd); chk("status_after_rst", rd, 32'd0);
        cpu(BASE + 32'h000, 32'd0, 4'd0, rd); chk("snap_after_rst", rd, 32'd0);
        cpu(BASE + 32'h4FC, 32'd0, 4'd0, rd); chk("obuf_after_rst", rd, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
